mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single-port unified instruction/data memory between the multicycle MIPS core and a DMA/loader requester. It sits between the requesters and `mem`, owns the memory's `we`/`a`/`wd` inputs, and returns per-requester grant and read data. Arbitration is burst-limited, with fixed CPU priority by default and optional round-robin. The core holds its state machine while `cpu_req & ~cpu_gnt`.

## Interface
- `WIDTH`, default 32: data and address width.
- `MAXBURST`, default 4: maximum consecutive granted beats for one owner while the other requester is waiting; must be ≥1.

Ports:
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `cpu_req`  in  1: CPU access request, held until granted.
- `cpu_we`  in  1: CPU write enable.
- `cpu_adr`  in  WIDTH: CPU byte address.
- `cpu_wd`  in  WIDTH: CPU write data.
- `cpu_gnt`  out  1: CPU access performed this cycle.
- `cpu_rd`  out  WIDTH: CPU read data, valid when `cpu_gnt`.
- `dma_req`, `dma_we`, `dma_adr`, `dma_wd`, `dma_gnt`, `dma_rd`: same as the CPU ports, for the DMA side.
- `mem_we`  out  1: memory write enable.
- `mem_adr`  out  WIDTH: memory address.
- `mem_wd`  out  WIDTH: memory write data.
- `mem_rd`  in  WIDTH: memory read data (combinational read).

## Operation
- State register `state` ∈ {IDLE, CPU, DMA}.
- Burst counter `beats`, width $clog2(MAXBURST+1).
- `last` register: owner of the most recent granted beat. Reset value: CPU.
- Access path:
  - In CPU or DMA state, `mem_adr`/`mem_wd` mux the owner's inputs.
  - `gnt_owner = req_owner`.
  - `mem_we = gnt_owner & we_owner & ~reset`.
  - `mem_rd` routes to both `cpu_rd` and `dma_rd`; only the granted side's value is meaningful.
- In IDLE: no grant, `mem_we`=0, `mem_adr`=0, `mem_wd`=0.
- Pick function, used in IDLE and at switch points: if only one requester is requesting, it wins. On contention, the winner follows the priority rule (see Configuration).
- Transitions, evaluated at each rising edge:
  - IDLE → pick(`cpu_req`, `dma_req`) if either is requesting; `beats`←0.
  - Owner state, owner requesting, other idle → stay; `beats`←0 (no limit without contention).
  - Owner state, owner requesting, other requesting, `beats+1` < MAXBURST → stay; `beats`++.
  - Owner state, owner requesting, other requesting, `beats+1` = MAXBURST → switch to the other; `beats`←0.
  - Owner state, owner not requesting → no access this cycle; go to the other if it is requesting, else IDLE; `beats`←0.
- Requests must not be withdrawn before grant; a withdrawal is tolerated and treated as the not-requesting case above.

## Timing
- Reset values:
  - `state`=IDLE, `beats`=0.
  - All grants 0; `mem_we`=0, `mem_adr`=0, `mem_wd`=0.
  - `cpu_rd`/`dma_rd` follow `mem_rd`.
- Latency from IDLE: request sampled at edge N; grant is asserted and the access occurs in cycle N+1.
- Back-to-back beats by the same owner: one per cycle, no bubble.
- Owner switch: the switch occurs at the edge; the new owner is granted in the next cycle, so no idle cycle is lost when the other is already requesting.
- Writes commit at the rising edge that ends the grant cycle. A read's data is valid combinationally during the grant cycle.
- Reset mid-burst: `mem_we` is forced low in the reset cycle, so no write commits. State returns to IDLE at the reset edge; requesters re-request afterwards.
- Grant combinational paths: `cpu_gnt`/`dma_gnt` depend only on the registered `state` and their own `req`.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`:
  - Undefined: fixed priority; CPU wins every contended pick.
  - Defined: the contended pick goes to the requester that is not `last`. `last` updates on every granted beat.
- The burst limit applies in both modes.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_CPU, ARB_DMA} arb_state_t`.
  - `typedef enum logic {OWN_CPU, OWN_DMA} arb_owner_t`.
- Sub-module `mem_arb_pick`: combinational pick from (`cpu_req`, `dma_req`, `last`). It contains the `MEM_ARB_ROUND_ROBIN_EN` conditional and outputs an `arb_owner_t` plus a `valid` flag.
- Top level holds the state register, burst counter, `last` register and access mux.

## Test plan
- Reset held 2 cycles, then `cpu_req`=1, `cpu_we`=0, `cpu_adr`=0x8 → `cpu_gnt`=1 in the second cycle after reset release; `cpu_rd`=RAM[2].
- `dma_req`=1, `dma_we`=1, `dma_adr`=0x54, `dma_wd`=7, CPU idle → one grant cycle, then RAM[21]=7; `mem_we` is high exactly 1 cycle.
- Both requesting continuously, MAXBURST=4, fixed priority → CPU granted 4 beats, DMA 4 beats, alternating; never more than 4 consecutive beats.
- Both request from IDLE simultaneously, with the previous beat owned by CPU → fixed mode grants CPU first; `MEM_ARB_ROUND_ROBIN_EN` grants DMA first.
- DMA mid-burst (beat 2) writing 0x55 to 0x40 when reset is asserted → `mem_we`=0 in the reset cycle, RAM[16] unchanged, IDLE next cycle, all grants 0.
- Owner drops `req` while the other is waiting → zero-grant cycle, then the other is granted the following cycle with `beats`=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter between the MIPS core and DMA.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin contention.
package mem_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_CPU, ARB_DMA} arb_state_t;
    typedef enum logic {OWN_CPU, OWN_DMA} arb_owner_t;

    function automatic arb_state_t owner_state(arb_owner_t o);
        return (o == OWN_DMA) ? ARB_DMA : ARB_CPU;
    endfunction

    function automatic arb_owner_t other_owner(arb_owner_t o);
        return (o == OWN_DMA) ? OWN_CPU : OWN_DMA;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory bus bundle shared by the arbiter and its neighbours.
// slave is the arbiter's view; master is the requesters'/memory's view.
interface mem_arbiter_if #(
    parameter int WIDTH = 32
);

    logic             cpu_req;
    logic             cpu_we;
    logic [WIDTH-1:0] cpu_adr;
    logic [WIDTH-1:0] cpu_wd;
    logic             cpu_gnt;
    logic [WIDTH-1:0] cpu_rd;

    logic             dma_req;
    logic             dma_we;
    logic [WIDTH-1:0] dma_adr;
    logic [WIDTH-1:0] dma_wd;
    logic             dma_gnt;
    logic [WIDTH-1:0] dma_rd;

    logic             mem_we;
    logic [WIDTH-1:0] mem_adr;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wd,
        output cpu_gnt, cpu_rd,
        input  dma_req, dma_we, dma_adr, dma_wd,
        output dma_gnt, dma_rd,
        output mem_we, mem_adr, mem_wd,
        input  mem_rd
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wd,
        input  cpu_gnt, cpu_rd,
        output dma_req, dma_we, dma_adr, dma_wd,
        input  dma_gnt, dma_rd,
        input  mem_we, mem_adr, mem_wd,
        output mem_rd
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational owner pick for an idle arbiter.
// Build option: MEM_ARB_ROUND_ROBIN_EN gives contention to the non-last owner.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_cpu_req,
    input  logic       i_dma_req,
    input  arb_owner_t i_last,
    output arb_owner_t o_owner,
    output logic       o_valid
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    arb_owner_t w_contended;

    // Fixed mode: the CPU always wins a tie.
    assign w_contended = (RR && i_last == OWN_CPU) ? OWN_DMA : OWN_CPU;

    assign o_valid = i_cpu_req | i_dma_req;
    assign o_owner = (i_cpu_req && i_dma_req) ? w_contended :
                     (i_dma_req ? OWN_DMA : OWN_CPU);

endmodule

// File: rtl/mem_arbiter.sv
// Burst-limited two-port arbiter sharing the unified memory (CPU and DMA).
// Build option: MEM_ARB_ROUND_ROBIN_EN enables round-robin contention picks.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAXBURST = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam int BW = $clog2(MAXBURST + 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [BW-1:0]    r_beats;
    logic [BW-1:0]    w_beats_nxt;
    arb_owner_t       r_last;
    arb_owner_t       w_last_nxt;

    arb_owner_t       w_pick_own;
    logic             w_pick_vld;
    arb_owner_t       w_own;
    logic             w_busy;
    logic             w_own_req;
    logic             w_oth_req;
    logic             w_own_we;
    logic [WIDTH-1:0] w_own_adr;
    logic [WIDTH-1:0] w_own_wd;
    logic             w_gnt;
    logic             w_at_limit;

    mem_arb_pick u_pick (
        .i_cpu_req (bus.cpu_req),
        .i_dma_req (bus.dma_req),
        .i_last    (r_last),
        .o_owner   (w_pick_own),
        .o_valid   (w_pick_vld)
    );

    assign w_busy = (r_state == ARB_CPU) || (r_state == ARB_DMA);
    assign w_own  = (r_state == ARB_DMA) ? OWN_DMA : OWN_CPU;

    always_comb begin
        w_own_req = bus.cpu_req;
        w_oth_req = bus.dma_req;
        w_own_we  = bus.cpu_we;
        w_own_adr = bus.cpu_adr;
        w_own_wd  = bus.cpu_wd;
        if (w_own == OWN_DMA) begin
            w_own_req = bus.dma_req;
            w_oth_req = bus.cpu_req;
            w_own_we  = bus.dma_we;
            w_own_adr = bus.dma_adr;
            w_own_wd  = bus.dma_wd;
        end
    end

    // Grants see only the registered state and their own request.
    assign bus.cpu_gnt = (r_state == ARB_CPU) & bus.cpu_req;
    assign bus.dma_gnt = (r_state == ARB_DMA) & bus.dma_req;
    assign w_gnt       = bus.cpu_gnt | bus.dma_gnt;

    assign bus.mem_we  = w_gnt & w_own_we & ~reset;
    assign bus.mem_adr = w_busy ? w_own_adr : '0;
    assign bus.mem_wd  = w_busy ? w_own_wd : '0;
    assign bus.cpu_rd  = bus.mem_rd;
    assign bus.dma_rd  = bus.mem_rd;

    assign w_at_limit = (int'(r_beats) + 1) >= MAXBURST;

    always_comb begin
        w_state_nxt = r_state;
        w_beats_nxt = '0;
        w_last_nxt  = w_gnt ? w_own : r_last;
        unique case (r_state)
            ARB_CPU, ARB_DMA: begin
                if (!w_own_req) begin
                    w_state_nxt = w_oth_req ?
                        owner_state(other_owner(w_own)) : ARB_IDLE;
                end else if (w_oth_req) begin
                    if (w_at_limit)
                        w_state_nxt = owner_state(other_owner(w_own));
                    else
                        w_beats_nxt = r_beats + 1'b1;
                end
            end
            default: begin
                w_state_nxt = w_pick_vld ?
                    owner_state(w_pick_own) : ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_beats <= '0;
            r_last  <= OWN_CPU;
        end else begin
            r_state <= w_state_nxt;
            r_beats <= w_beats_nxt;
            r_last  <= w_last_nxt;
        end
    end

endmodule
